grid_selection_ctrl: RTL and testbench

//   Sequences the 3x3 OLED selection grid. Turns one-cycle button pulses into a

---
 rtl/grid_selection_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_grid_selection_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/grid_selection_ctrl.sv
// grid_selection_ctrl
//   Sequences the 3x3 OLED selection grid. One-cycle button pulses move a
//   cursor and toggle marks; the result is rendered as 2 bits per cell
//   (2'b11 = box drawn, 2'b00 = blank) together with the box colour.
//   Build option: define WRAP_EN to make edge moves wrap within the
//   row/column; left undefined, edge moves saturate.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       pulse, IDLE -> EDIT
//   btn_up      pulse, cursor row-1
//   btn_down    pulse, cursor row+1
//   btn_left    pulse, cursor col-1
//   btn_right   pulse, cursor col+1
//   btn_center  pulse, toggle mark at cursor
//   confirm     pulse, EDIT -> LOCKED (needs at least one mark)
//   clear       pulse, any state -> IDLE with marks cleared
//   grid_data   cell i (i = row*3+col, row 0 top) at [2i+1:2i]
//   color_hex   RGB565 colour for drawn boxes
//   sel_count   number of marked cells
//   locked      high while LOCKED
//
// State table
//   state     | meaning
//   ST_IDLE   | grid blank, waiting for start
//   ST_EDIT   | cursor blinks, buttons move cursor and toggle marks
//   ST_LOCKED | marks frozen and shown in lock colour, no cursor

module grid_selection_ctrl #(
   parameter int unsigned BLINK_CYCLES = 6_250_000,
   parameter int unsigned MAX_SEL      = 3,
   parameter logic [15:0] EDIT_COLOR   = 16'h07E0,
   parameter logic [15:0] LOCK_COLOR   = 16'hF800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_center,
   input  logic        confirm,
   input  logic        clear,
   output logic [17:0] grid_data,
   output logic [15:0] color_hex,
   output logic [3:0]  sel_count,
   output logic        locked
);

`ifdef WRAP_EN
   localparam logic WRAP = 1'b1;
`else
   localparam logic WRAP = 1'b0;
`endif

   localparam int unsigned  CW         = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);
   localparam logic [3:0]   MAX_SEL_C  = 4'(MAX_SEL);
   localparam logic [3:0]   CENTRE     = 4'd4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EDIT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t        state, nxt_state;
   logic [3:0]    cursor, nxt_cursor;
   logic [8:0]    marks, nxt_marks;
   logic [3:0]    sel_cnt, nxt_sel_cnt;
   logic [CW-1:0] blink_cnt, nxt_blink_cnt;
   logic          blink_on, nxt_blink_on;
   logic          restart;
   logic          at_top, at_bottom, at_left, at_right;
   logic [17:0]   nxt_grid;
   logic [15:0]   nxt_color;

   assign at_top    = (cursor < 4'd3);
   assign at_bottom = (cursor >= 4'd6);
   assign at_left   = (cursor == 4'd0) || (cursor == 4'd3) || (cursor == 4'd6);
   assign at_right  = (cursor == 4'd2) || (cursor == 4'd5) || (cursor == 4'd8);

   always_comb begin
      nxt_state     = state;
      nxt_cursor    = cursor;
      nxt_marks     = marks;
      nxt_sel_cnt   = sel_cnt;
      nxt_blink_cnt = blink_cnt;
      nxt_blink_on  = blink_on;
      restart       = 1'b0;

      if (clear) begin
         nxt_state     = ST_IDLE;
         nxt_cursor    = CENTRE;
         nxt_marks     = '0;
         nxt_sel_cnt   = '0;
         nxt_blink_cnt = '0;
         nxt_blink_on  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  nxt_state     = ST_EDIT;
                  nxt_cursor    = CENTRE;
                  nxt_blink_cnt = '0;
                  nxt_blink_on  = 1'b1;
               end
            end
            ST_EDIT: begin
               // An ignored confirm (nothing marked) is not an action, so a
               // lower-priority button in the same cycle still applies.
               if (confirm && (sel_cnt != 4'd0)) begin
                  nxt_state = ST_LOCKED;
               end else if (btn_center) begin
                  restart = 1'b1;
                  if (marks[cursor]) begin
                     nxt_marks[cursor] = 1'b0;
                     nxt_sel_cnt       = sel_cnt - 4'd1;
                  end else if (sel_cnt < MAX_SEL_C) begin
                     nxt_marks[cursor] = 1'b1;
                     nxt_sel_cnt       = sel_cnt + 4'd1;
                  end
               end else if (btn_up) begin
                  restart = 1'b1;
                  if (!at_top)   nxt_cursor = cursor - 4'd3;
                  else if (WRAP) nxt_cursor = cursor + 4'd6;
               end else if (btn_down) begin
                  restart = 1'b1;
                  if (!at_bottom) nxt_cursor = cursor + 4'd3;
                  else if (WRAP)  nxt_cursor = cursor - 4'd6;
               end else if (btn_left) begin
                  restart = 1'b1;
                  if (!at_left)  nxt_cursor = cursor - 4'd1;
                  else if (WRAP) nxt_cursor = cursor + 4'd2;
               end else if (btn_right) begin
                  restart = 1'b1;
                  if (!at_right) nxt_cursor = cursor + 4'd1;
                  else if (WRAP) nxt_cursor = cursor - 4'd2;
               end

               // Any action restarts the blink so the cursor is visible at once.
               if (restart) begin
                  nxt_blink_cnt = '0;
                  nxt_blink_on  = 1'b1;
               end else if (blink_cnt == BLINK_LAST) begin
                  nxt_blink_cnt = '0;
                  nxt_blink_on  = ~blink_on;
               end else begin
                  nxt_blink_cnt = blink_cnt + 1'b1;
               end
            end
            ST_LOCKED: begin
            end
            default: begin
               nxt_state = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are rendered from the next-state values so they register
   // together with the state, one cycle after the causing input.
   always_comb begin
      nxt_grid = '0;
      for (int i = 0; i < 9; i++) begin
         nxt_grid[2*i +: 2] = {2{nxt_marks[i] |
                                 ((nxt_state == ST_EDIT) && (nxt_cursor == 4'(i)) && nxt_blink_on)}};
      end
      case (nxt_state)
         ST_EDIT:   nxt_color = EDIT_COLOR;
         ST_LOCKED: nxt_color = LOCK_COLOR;
         default:   nxt_color = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cursor    <= CENTRE;
         marks     <= '0;
         sel_cnt   <= '0;
         blink_cnt <= '0;
         blink_on  <= 1'b1;
         grid_data <= '0;
         color_hex <= '0;
         sel_count <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= nxt_state;
         cursor    <= nxt_cursor;
         marks     <= nxt_marks;
         sel_cnt   <= nxt_sel_cnt;
         blink_cnt <= nxt_blink_cnt;
         blink_on  <= nxt_blink_on;
         grid_data <= nxt_grid;
         color_hex <= nxt_color;
         sel_count <= nxt_sel_cnt;
         locked    <= (nxt_state == ST_LOCKED);
      end
   end

endmodule

// File: tb/tb_grid_selection_ctrl.sv
// tb_grid_selection_ctrl
//   Directed bench for grid_selection_ctrl with BLINK_CYCLES=4, MAX_SEL=3.
//   Buttons are pulsed for one cycle; outputs are sampled 1 time unit after
//   the clock edge that registers them.

module tb_grid_selection_ctrl;

   localparam logic [7:0] B_START  = 8'h01;
   localparam logic [7:0] B_UP     = 8'h02;
   localparam logic [7:0] B_DOWN   = 8'h04;
   localparam logic [7:0] B_LEFT   = 8'h08;
   localparam logic [7:0] B_RIGHT  = 8'h10;
   localparam logic [7:0] B_CENTER = 8'h20;
   localparam logic [7:0] B_CONF   = 8'h40;
   localparam logic [7:0] B_CLEAR  = 8'h80;
   localparam logic [7:0] B_NONE   = 8'h00;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, btn_up, btn_down, btn_left, btn_right, btn_center;
   logic        confirm, clear;
   logic [17:0] grid_data;
   logic [15:0] color_hex;
   logic [3:0]  sel_count;
   logic        locked;

   int total = 0;
   int bad   = 0;

   grid_selection_ctrl #(
      .BLINK_CYCLES (4),
      .MAX_SEL      (3),
      .EDIT_COLOR   (16'h07E0),
      .LOCK_COLOR   (16'hF800)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .btn_up     (btn_up),
      .btn_down   (btn_down),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_center (btn_center),
      .confirm    (confirm),
      .clear      (clear),
      .grid_data  (grid_data),
      .color_hex  (color_hex),
      .sel_count  (sel_count),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [7:0] m);
      start      = m[0];
      btn_up     = m[1];
      btn_down   = m[2];
      btn_left   = m[3];
      btn_right  = m[4];
      btn_center = m[5];
      confirm    = m[6];
      clear      = m[7];
      @(posedge clk);
      #1;
      start      = 1'b0;
      btn_up     = 1'b0;
      btn_down   = 1'b0;
      btn_left   = 1'b0;
      btn_right  = 1'b0;
      btn_center = 1'b0;
      confirm    = 1'b0;
      clear      = 1'b0;
   endtask

   task automatic chk_all(input string tag, input logic [17:0] g, input logic [15:0] c,
                          input logic [3:0] s, input logic l);
      chk({tag, "_grid"},  32'(grid_data), 32'(g));
      chk({tag, "_color"}, 32'(color_hex), 32'(c));
      chk({tag, "_sel"},   32'(sel_count), 32'(s));
      chk({tag, "_lock"},  32'(locked),    32'(l));
   endtask

   initial begin
      rst = 1'b1;
      press(B_NONE);
      press(B_NONE);
      rst = 1'b0;
      press(B_NONE);
      chk_all("reset", 18'h0, 16'h0, 4'd0, 1'b0);

      // start -> cursor at centre, edit colour
      press(B_START);
      chk_all("start", 18'h00300, 16'h07E0, 4'd0, 1'b0);

      // blink: on for 4 cycles, off for 4, on again
      for (int k = 1; k <= 8; k++) begin
         press(B_NONE);
         chk($sformatf("blink%0d", k), 32'(grid_data),
             ((k < 4) || (k == 8)) ? 32'h00300 : 32'h0);
      end

      press(B_UP);
      chk("up_to1", 32'(grid_data), 32'h0000C);

      // mark 0,1,2
      press(B_LEFT);   chk("left_to0", 32'(grid_data), 32'h00003);
      press(B_CENTER); chk("mark0_sel", 32'(sel_count), 32'd1);
      press(B_RIGHT);  chk("right_to1", 32'(grid_data), 32'h0000F);
      press(B_CENTER); chk("mark1_sel", 32'(sel_count), 32'd2);
      press(B_RIGHT);  chk("right_to2", 32'(grid_data), 32'h0003F);
      press(B_CENTER); chk("mark2_sel", 32'(sel_count), 32'd3);
      press(B_DOWN);   chk("down_to5", 32'(grid_data), 32'h00C3F);
      press(B_LEFT);   chk("left_to4", 32'(grid_data), 32'h0033F);
      press(B_LEFT);   chk("left_to3", 32'(grid_data), 32'h000FF);

      // fourth mark rejected at MAX_SEL
      press(B_CENTER);
      chk("reject_sel", 32'(sel_count), 32'd3);
      press(B_UP);
      chk("reject_unmarked3", 32'(grid_data), 32'h0003F);
      press(B_CENTER);
      chk("unmark0_sel", 32'(sel_count), 32'd2);
      for (int k = 0; k < 4; k++) press(B_NONE);
      chk("unmark0_grid", 32'(grid_data), 32'h0003C);

      // up+left from cell 4: up wins
      press(B_DOWN);
      press(B_RIGHT);
      chk("at4", 32'(grid_data), 32'h0033C);
      press(B_UP | B_LEFT);
      chk("upleft_up_wins", 32'(grid_data), 32'h0003C);
      press(B_DOWN);
      chk("back_to4", 32'(grid_data), 32'h0033C);

      // confirm beats centre: locked, marks unchanged
      press(B_CONF | B_CENTER);
      chk_all("lock1", 18'h0003C, 16'hF800, 4'd2, 1'b1);

      press(B_CLEAR);
      chk_all("clear1", 18'h0, 16'h0, 4'd0, 1'b0);

      // edge move at column 2
      press(B_START);
      press(B_UP);
      press(B_RIGHT);
      chk("at2", 32'(grid_data), 32'h00030);
      press(B_RIGHT);
`ifdef WRAP_EN
      chk("edge_right", 32'(grid_data), 32'h00003);
`else
      chk("edge_right", 32'(grid_data), 32'h00030);
`endif

      // confirm with nothing marked is ignored
      press(B_CONF);
      chk("empty_confirm_lock", 32'(locked), 32'd0);
      chk("empty_confirm_color", 32'(color_hex), 32'h07E0);

      // marks {0,8} then lock
      press(B_CLEAR);
      press(B_START);
      press(B_UP);
      press(B_LEFT);
      press(B_CENTER);
      press(B_DOWN);
      press(B_DOWN);
      press(B_RIGHT);
      press(B_RIGHT);
      press(B_CENTER);
      chk("mark08_sel", 32'(sel_count), 32'd2);
      press(B_CONF);
      chk_all("lock08", 18'h30003, 16'hF800, 4'd2, 1'b1);
      press(B_UP);
      chk("locked_ignores_move", 32'(grid_data), 32'h30003);
      press(B_CLEAR);
      chk_all("clear2", 18'h0, 16'h0, 4'd0, 1'b0);

      // synchronous reset in the middle of editing
      press(B_START);
      press(B_UP);
      press(B_CENTER);
      chk("pre_rst_sel", 32'(sel_count), 32'd1);
      rst = 1'b1;
      press(B_NONE);
      chk_all("mid_rst", 18'h0, 16'h0, 4'd0, 1'b0);
      rst = 1'b0;
      press(B_START);
      chk_all("restart", 18'h00300, 16'h07E0, 4'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      start = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0;
      btn_right = 1'b0; btn_center = 1'b0; confirm = 1'b0; clear = 1'b0;
   end

endmodule
